// File: rtl/spmv_pkg.sv
// spmv_pkg: shared types for the sparse matrix-vector row accumulator.
//   state_t    - controller states (IDLE, LOAD_LEN, ACCUM, EMIT, DONE)
//   P16/P32/P64 - operand precision codes (code 3 behaves as 64-bit)
//   sext64     - sign-extends a right-aligned operand to 64 bits
package spmv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_LEN = 3'd1,
    ST_ACCUM    = 3'd2,
    ST_EMIT     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [1:0] P16 = 2'd0;
  localparam logic [1:0] P32 = 2'd1;
  localparam logic [1:0] P64 = 2'd2;

  function automatic logic [63:0] sext64(input logic [63:0] d, input logic [1:0] prec);
    logic [63:0] r;
    case (prec)
      P16:     r = {{48{d[15]}}, d[15:0]};
      P32:     r = {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spmv_row_accum_if.sv
// spmv_row_accum_if: the four valid/ready streams of the row accumulator.
//   Xi     - vector operand stream (64-bit, right-aligned)
//   Val    - matrix value stream   (64-bit, right-aligned)
//   RowLen - non-zeros per row     (ROWLEN_W bits)
//   Y      - per-row result stream (64-bit)
// modport slave  : the accumulator side (consumes Xi/Val/RowLen, produces Y)
// modport master : the environment side
interface spmv_row_accum_if #(parameter int ROWLEN_W = 32) ();

  logic                Xi_valid;
  logic [63:0]         Xi_data;
  logic                Xi_ready;
  logic                Val_valid;
  logic [63:0]         Val_data;
  logic                Val_ready;
  logic                RowLen_valid;
  logic [ROWLEN_W-1:0] RowLen_data;
  logic                RowLen_ready;
  logic                Y_valid;
  logic [63:0]         Y_data;
  logic                Y_ready;

  modport slave (
    input  Xi_valid, Xi_data, Val_valid, Val_data, RowLen_valid, RowLen_data, Y_ready,
    output Xi_ready, Val_ready, RowLen_ready, Y_valid, Y_data
  );

  modport master (
    output Xi_valid, Xi_data, Val_valid, Val_data, RowLen_valid, RowLen_data, Y_ready,
    input  Xi_ready, Val_ready, RowLen_ready, Y_valid, Y_data
  );

endinterface

// File: rtl/spmv_sext_mul.sv
// spmv_sext_mul: sign-extends both operands to 64 bits according to their
// precision codes and registers the low 64 bits of the signed product.
//   clk, rstn                  - clock, asynchronous active-low reset
//   fire_i                     - operand pair present this cycle
//   xi_i, val_i                - right-aligned operands
//   xi_prec_i, val_prec_i      - precision codes
//   prod_valid_o, prod_o       - product, valid the cycle after fire_i
module spmv_sext_mul (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fire_i,
  input  logic [63:0] xi_i,
  input  logic [63:0] val_i,
  input  logic [1:0]  xi_prec_i,
  input  logic [1:0]  val_prec_i,
  output logic        prod_valid_o,
  output logic [63:0] prod_o
);
  import spmv_pkg::*;

  logic [63:0] xi_ext;
  logic [63:0] val_ext;
  logic [63:0] prod_d;
  logic [63:0] prod_q;
  logic        prod_valid_q;

  // The low 64 bits of a product are identical for signed and unsigned
  // interpretation once both operands are sign-extended to 64 bits.
  always_comb begin
    xi_ext  = sext64(xi_i, xi_prec_i);
    val_ext = sext64(val_i, val_prec_i);
    prod_d  = xi_ext * val_ext;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      prod_valid_q <= fire_i;
      if (fire_i) prod_q <= prod_d;
    end
  end

  assign prod_o       = prod_q;
  assign prod_valid_o = prod_valid_q;

endmodule

// File: rtl/spmv_row_accum.sv
// spmv_row_accum: per-row dot-product accumulator for sparse matrix-vector
// multiply. For each of Row_Count rows it takes a row length, pairs that many
// Xi and Val beats, accumulates the signed products modulo 2^64 and emits
// one Y beat per row, followed by a one-cycle Done pulse.
//   clk, rstn                 - clock, asynchronous active-low reset
//   Calc_Begin, Row_Count     - start pulse and row count (IDLE only)
//   Ctrl_sig_Xi, Ctrl_sig_Val - operand precision codes
//   bus                       - Xi / Val / RowLen / Y streams
//   Busy, Done                - status
module spmv_row_accum #(
  parameter int ROWLEN_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                Calc_Begin,
  input  logic [ROWLEN_W-1:0] Row_Count,
  input  logic [1:0]          Ctrl_sig_Xi,
  input  logic [1:0]          Ctrl_sig_Val,
  spmv_row_accum_if.slave     bus,
  output logic                Busy,
  output logic                Done
);
  import spmv_pkg::*;

  state_t              state_q;
  logic [ROWLEN_W-1:0] rows_rem_q;
  logic [ROWLEN_W-1:0] len_q;
  logic [ROWLEN_W-1:0] xi_cnt_q;
  logic [ROWLEN_W-1:0] val_cnt_q;
  logic [ROWLEN_W-1:0] acc_cnt_q;
  logic [63:0]         xi_hold_q;
  logic [63:0]         val_hold_q;
  logic                xi_full_q;
  logic                val_full_q;
  logic [63:0]         acc_q;
  logic                y_valid_q;
  logic [63:0]         y_data_q;
  logic                busy_q;
  logic                done_q;

  logic        xi_rdy, val_rdy, rl_rdy;
  logic        xi_xfer, val_xfer, rl_xfer, y_xfer;
  logic        fire;
  logic        prod_valid;
  logic [63:0] prod;

  // Readies depend only on registered state so upstream valid may depend on them.
  assign rl_rdy   = (state_q == ST_LOAD_LEN);
  assign xi_rdy   = (state_q == ST_ACCUM) && !xi_full_q  && (xi_cnt_q  < len_q);
  assign val_rdy  = (state_q == ST_ACCUM) && !val_full_q && (val_cnt_q < len_q);
  assign rl_xfer  = bus.RowLen_valid && rl_rdy;
  assign xi_xfer  = bus.Xi_valid && xi_rdy;
  assign val_xfer = bus.Val_valid && val_rdy;
  assign y_xfer   = y_valid_q && bus.Y_ready;
  assign fire     = (state_q == ST_ACCUM) && xi_full_q && val_full_q;

  spmv_sext_mul u_mul (
    .clk          (clk),
    .rstn         (rstn),
    .fire_i       (fire),
    .xi_i         (xi_hold_q),
    .val_i        (val_hold_q),
    .xi_prec_i    (Ctrl_sig_Xi),
    .val_prec_i   (Ctrl_sig_Val),
    .prod_valid_o (prod_valid),
    .prod_o       (prod)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rows_rem_q <= '0;
      len_q      <= '0;
      xi_cnt_q   <= '0;
      val_cnt_q  <= '0;
      acc_cnt_q  <= '0;
      xi_hold_q  <= '0;
      val_hold_q <= '0;
      xi_full_q  <= 1'b0;
      val_full_q <= 1'b0;
      acc_q      <= '0;
      y_valid_q  <= 1'b0;
      y_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Calc_Begin) begin
            rows_rem_q <= Row_Count;
            busy_q     <= 1'b1;
            if (Row_Count == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD_LEN;
            end
          end
        end
        ST_LOAD_LEN: begin
          if (rl_xfer) begin
            len_q     <= bus.RowLen_data;
            acc_q     <= '0;
            xi_cnt_q  <= '0;
            val_cnt_q <= '0;
            acc_cnt_q <= '0;
            if (bus.RowLen_data == '0) begin
              state_q   <= ST_EMIT;
              y_valid_q <= 1'b1;
              y_data_q  <= '0;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          // A holding register is never loaded and fired in the same cycle:
          // loading needs it empty, firing needs it full.
          if (xi_xfer) begin
            xi_hold_q <= bus.Xi_data;
            xi_full_q <= 1'b1;
            xi_cnt_q  <= xi_cnt_q + ROWLEN_W'(1);
          end
          if (val_xfer) begin
            val_hold_q <= bus.Val_data;
            val_full_q <= 1'b1;
            val_cnt_q  <= val_cnt_q + ROWLEN_W'(1);
          end
          if (fire) begin
            xi_full_q  <= 1'b0;
            val_full_q <= 1'b0;
          end
          if (prod_valid) begin
            acc_q     <= acc_q + prod;
            acc_cnt_q <= acc_cnt_q + ROWLEN_W'(1);
          end
          // Checked on the registered count, so the row closes the cycle
          // after the last product lands in the accumulator.
          if (acc_cnt_q == len_q) begin
            state_q   <= ST_EMIT;
            y_valid_q <= 1'b1;
            y_data_q  <= acc_q;
          end
        end
        ST_EMIT: begin
          if (y_xfer) begin
            y_valid_q  <= 1'b0;
            rows_rem_q <= rows_rem_q - ROWLEN_W'(1);
            if (rows_rem_q == ROWLEN_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD_LEN;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Xi_ready     = xi_rdy;
  assign bus.Val_ready    = val_rdy;
  assign bus.RowLen_ready = rl_rdy;
  assign bus.Y_valid      = y_valid_q;
  assign bus.Y_data       = y_data_q;
  assign Busy             = busy_q;
  assign Done             = done_q;

endmodule

// File: tb/tb_spmv_row_accum.sv
// tb_spmv_row_accum: directed self-checking bench for spmv_row_accum.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_spmv_row_accum;

  logic        clk;
  logic        rstn;
  logic        Calc_Begin;
  logic [31:0] Row_Count;
  logic [1:0]  Ctrl_sig_Xi;
  logic [1:0]  Ctrl_sig_Val;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;
  int xi_xfers = 0;
  int val_xfers = 0;
  int rl_xfers = 0;
  int done_cnt = 0;

  spmv_row_accum_if #(.ROWLEN_W(32)) bus ();

  spmv_row_accum #(.ROWLEN_W(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .Calc_Begin   (Calc_Begin),
    .Row_Count    (Row_Count),
    .Ctrl_sig_Xi  (Ctrl_sig_Xi),
    .Ctrl_sig_Val (Ctrl_sig_Val),
    .bus          (bus),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // valid and ready are both stable at the falling edge, so a handshake seen
  // here is the one the following rising edge will take.
  always @(negedge clk) begin
    if (bus.Xi_valid && bus.Xi_ready) xi_xfers++;
    if (bus.Val_valid && bus.Val_ready) val_xfers++;
    if (bus.RowLen_valid && bus.RowLen_ready) rl_xfers++;
    if (Done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // which: 0 = RowLen, 1 = Xi, 2 = Val
  task automatic send_beat(input int which, input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    case (which)
      0:       begin bus.RowLen_valid = 1'b1; bus.RowLen_data = d[31:0]; end
      1:       begin bus.Xi_valid = 1'b1; bus.Xi_data = d; end
      default: begin bus.Val_valid = 1'b1; bus.Val_data = d; end
    endcase
    for (int c = 0; c < 300; c++) begin
      if ((which == 0 && bus.RowLen_ready) || (which == 1 && bus.Xi_ready) ||
          (which == 2 && bus.Val_ready)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    case (which)
      0:       bus.RowLen_valid = 1'b0;
      1:       bus.Xi_valid = 1'b0;
      default: bus.Val_valid = 1'b0;
    endcase
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout stream=%0d got no ready, required ready within 300 cycles", which);
    end
  endtask

  task automatic recv_y(output logic [63:0] d);
    bit ok;
    ok = 1'b0;
    bus.Y_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (bus.Y_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    d = bus.Y_data;
    if (ok) @(negedge clk);
    bus.Y_ready = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      d = 'x;
      $display("FAIL y_timeout got no Y_valid, required Y_valid within 300 cycles");
    end else begin
      $display("Y beat data=%h", d);
    end
  endtask

  task automatic start(input logic [31:0] n);
    Row_Count  = n;
    Calc_Begin = 1'b1;
    @(negedge clk);
    Calc_Begin = 1'b0;
  endtask

  task automatic run_one(input logic [1:0] px, input logic [1:0] pv,
                         input logic [63:0] xi, input logic [63:0] val,
                         output logic [63:0] y);
    Ctrl_sig_Xi  = px;
    Ctrl_sig_Val = pv;
    start(32'd1);
    send_beat(0, 64'd1);
    fork
      send_beat(1, xi);
      send_beat(2, val);
    join
    recv_y(y);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (bus.Y_valid !== 1'b0) begin errors++; $display("FAIL reset_yvalid got %b want 0", bus.Y_valid); end
    checks++; if (bus.Xi_ready !== 1'b0) begin errors++; $display("FAIL reset_xi_ready got %b want 0", bus.Xi_ready); end
    checks++; if (bus.Val_ready !== 1'b0) begin errors++; $display("FAIL reset_val_ready got %b want 0", bus.Val_ready); end
    checks++; if (bus.RowLen_ready !== 1'b0) begin errors++; $display("FAIL reset_rl_ready got %b want 0", bus.RowLen_ready); end
    checks++; if (bus.Y_data !== 64'd0) begin errors++; $display("FAIL reset_ydata got %h want 0", bus.Y_data); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] y;
    int d0;
    d0 = done_cnt;
    Ctrl_sig_Xi  = 2'd2;
    Ctrl_sig_Val = 2'd2;
    start(32'd1);
    fork
      send_beat(0, 64'd3);
      begin send_beat(1, 64'd1); send_beat(1, 64'd2); send_beat(1, 64'd3); end
      begin send_beat(2, 64'd4); send_beat(2, 64'd5); send_beat(2, 64'd6); end
      recv_y(y);
    join
    repeat (3) @(negedge clk);
    checks++; if (y !== 64'd32) begin errors++; $display("FAIL basic_y got %h want %h", y, 64'd32); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt - d0); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_idle got Busy=%b want 0", Busy); end
  endtask

  task automatic test_latency();
    logic [63:0] y;
    bit early;
    Ctrl_sig_Xi  = 2'd2;
    Ctrl_sig_Val = 2'd2;
    start(32'd1);
    send_beat(0, 64'd1);
    fork
      send_beat(1, 64'd7);
      send_beat(2, 64'hFFFF_FFFF_FFFF_FFFD);
    join
    // Now in the fire cycle; Y_valid is due three cycles later.
    early = bus.Y_valid;
    @(negedge clk);
    early = early | bus.Y_valid;
    @(negedge clk);
    early = early | bus.Y_valid;
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL latency_early got Y_valid before fire+3 want low"); end
    @(negedge clk);
    checks++; if (bus.Y_valid !== 1'b1) begin errors++; $display("FAIL latency_rise got Y_valid=%b at fire+3 want 1", bus.Y_valid); end
    recv_y(y);
    repeat (3) @(negedge clk);
    checks++; if (y !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL latency_y got %h want FFFFFFFFFFFFFFEB", y); end
  endtask

  task automatic test_precision();
    logic [63:0] y;
    run_one(2'd0, 2'd0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0002, y);
    checks++; if (y !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL p16_y got %h want FFFFFFFFFFFFFFFE", y); end
    run_one(2'd1, 2'd1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0002, y);
    checks++; if (y !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL p32_y got %h want FFFFFFFF00000000", y); end
    run_one(2'd1, 2'd0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0003, y);
    checks++; if (y !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL mixed_y got %h want FFFFFFFFFFFFFFFD", y); end
  endtask

  task automatic test_zero_len();
    logic [63:0] y0, y1;
    int x0;
    x0 = xi_xfers;
    Ctrl_sig_Xi  = 2'd2;
    Ctrl_sig_Val = 2'd2;
    start(32'd2);
    fork
      begin send_beat(0, 64'd0); send_beat(0, 64'd2); end
      begin send_beat(1, 64'd7); send_beat(1, 64'd7); end
      begin send_beat(2, 64'd1); send_beat(2, 64'd1); end
      begin recv_y(y0); recv_y(y1); end
    join
    repeat (3) @(negedge clk);
    checks++; if (y0 !== 64'd0) begin errors++; $display("FAIL zlen_y0 got %h want 0", y0); end
    checks++; if (y1 !== 64'd14) begin errors++; $display("FAIL zlen_y1 got %h want %h", y1, 64'd14); end
    checks++; if (xi_xfers - x0 != 2) begin errors++; $display("FAIL zlen_xi_beats got %0d want 2", xi_xfers - x0); end
  endtask

  task automatic test_backpressure();
    logic [63:0] y0, y1, y_hold;
    bit stable;
    int r0;
    Ctrl_sig_Xi  = 2'd2;
    Ctrl_sig_Val = 2'd2;
    start(32'd2);
    fork
      begin send_beat(0, 64'd1); send_beat(0, 64'd1); end
      begin send_beat(1, 64'd5); send_beat(1, 64'd1); end
      begin send_beat(2, 64'd6); send_beat(2, 64'd1); end
      begin
        for (int c = 0; c < 300 && !bus.Y_valid; c++) @(negedge clk);
        r0 = rl_xfers;
        y_hold = bus.Y_data;
        stable = bus.Y_valid;
        repeat (10) begin
          @(negedge clk);
          if (!bus.Y_valid || bus.Y_data !== y_hold) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable got Y changed or dropped while stalled want held"); end
        checks++; if (rl_xfers != r0) begin errors++; $display("FAIL bp_rowlen got %0d extra lengths want 0", rl_xfers - r0); end
        recv_y(y0);
        recv_y(y1);
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (y0 !== 64'd30) begin errors++; $display("FAIL bp_y0 got %h want %h", y0, 64'd30); end
    checks++; if (y1 !== 64'd1) begin errors++; $display("FAIL bp_y1 got %h want 1", y1); end
  endtask

  task automatic test_skew();
    logic [63:0] y;
    int v0, x0;
    v0 = val_xfers;
    x0 = xi_xfers;
    Ctrl_sig_Xi  = 2'd2;
    Ctrl_sig_Val = 2'd2;
    start(32'd1);
    send_beat(0, 64'd1);
    fork
      send_beat(2, 64'hFFFF_FFFF_FFFF_FFFE);
      begin
        repeat (5) @(negedge clk);
        checks++; if (bus.Val_ready !== 1'b0 || val_xfers - v0 != 1) begin
          errors++; $display("FAIL skew_val_held got Val_ready=%b beats=%0d want 0 and 1", bus.Val_ready, val_xfers - v0);
        end
        send_beat(1, 64'd9);
      end
      recv_y(y);
    join
    repeat (3) @(negedge clk);
    checks++; if (y !== 64'hFFFF_FFFF_FFFF_FFEE) begin errors++; $display("FAIL skew_y got %h want FFFFFFFFFFFFFFEE", y); end
    checks++; if (val_xfers - v0 != 1 || xi_xfers - x0 != 1) begin
      errors++; $display("FAIL skew_beats got val=%0d xi=%0d want 1 and 1", val_xfers - v0, xi_xfers - x0);
    end
  endtask

  task automatic test_zero_rows();
    int d0;
    d0 = done_cnt;
    start(32'd0);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zrows_done got %0d pulses want 1", done_cnt - d0); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL zrows_idle got Busy=%b want 0", Busy); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] y;
    int d0;
    Ctrl_sig_Xi  = 2'd2;
    Ctrl_sig_Val = 2'd2;
    start(32'd1);
    send_beat(0, 64'd3);
    send_beat(1, 64'd100);
    send_beat(2, 64'd100);
    send_beat(1, 64'd50);
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (Busy !== 1'b0 || bus.Y_valid !== 1'b0 || done_cnt != d0) begin
      errors++; $display("FAIL rmid_quiet got Busy=%b Y_valid=%b done=%0d want 0 0 0", Busy, bus.Y_valid, done_cnt - d0);
    end
    run_one(2'd2, 2'd2, 64'd2, 64'd3, y);
    checks++; if (y !== 64'd6) begin errors++; $display("FAIL rmid_y got %h want 6", y); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rmid_done got %0d pulses want 1", done_cnt - d0); end
  endtask

  initial begin
    rstn             = 1'b0;
    Calc_Begin       = 1'b0;
    Row_Count        = '0;
    Ctrl_sig_Xi      = 2'd2;
    Ctrl_sig_Val     = 2'd2;
    bus.Xi_valid     = 1'b0;
    bus.Xi_data      = '0;
    bus.Val_valid    = 1'b0;
    bus.Val_data     = '0;
    bus.RowLen_valid = 1'b0;
    bus.RowLen_data  = '0;
    bus.Y_ready      = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_latency();
    test_precision();
    test_zero_len();
    test_backpressure();
    test_skew();
    test_zero_rows();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spmv_row_accum.md
SPMV_ROW_ACCUM -- requirements
Module: spmv_row_accum

Interface
REQ-001 SHALL have parameter ROWLEN_W, default 32, width of row-length and row-count fields.
REQ-002 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port Calc_Begin  in  1  start pulse, sampled in IDLE only.
REQ-005 SHALL have port Row_Count  in  ROWLEN_W  rows to process, latched on Calc_Begin.
REQ-006 SHALL have port Ctrl_sig_Xi  in  2  Xi precision: 0=16b, 1=32b, 2=64b, 3=64b.
REQ-007 SHALL have port Ctrl_sig_Val  in  2  Val precision, same encoding.
REQ-008 SHALL have port Xi_valid  in  1  and Xi_data  in  64  Xi operand stream, right-aligned.
REQ-009 SHALL have port Xi_ready  out  1  Xi accept.
REQ-010 SHALL have port Val_valid  in  1  and Val_data  in  64  matrix value stream, right-aligned.
REQ-011 SHALL have port Val_ready  out  1  Val accept.
REQ-012 SHALL have port RowLen_valid  in  1  and RowLen_data  in  ROWLEN_W  non-zeros per row.
REQ-013 SHALL have port RowLen_ready  out  1  row-length accept.
REQ-014 SHALL have port Y_valid  out  1,  Y_data  out  64,  Y_ready  in  1  per-row result stream.
REQ-015 SHALL have port Busy  out  1  high outside IDLE; Done  out  1  one-cycle completion pulse.

Function
REQ-016 SHALL transfer on any stream only in cycles where valid and ready are both high.
REQ-017 SHALL never derive Xi_ready, Val_ready or RowLen_ready combinationally from any valid input (upstream Xi valid depends on Xi_ready).
REQ-018 SHALL implement states IDLE, LOAD_LEN, ACCUM, EMIT, DONE.
REQ-019 IDLE: on Calc_Begin latch Row_Count; go DONE if Row_Count==0, else LOAD_LEN.
REQ-020 LOAD_LEN: RowLen_ready=1; on transfer latch length, clear accumulator; go EMIT if length==0, else ACCUM.
REQ-021 ACCUM: Xi_ready=1 when Xi holding register empty and pairs-accepted < length; Val_ready likewise for the Val holding register.
REQ-022 SHALL fire a pair in the cycle both holding registers are full, emptying both (ready may re-assert next cycle).
REQ-023 Operands SHALL be sign-extended to 64 bits per their precision code; product SHALL be low 64 bits of the signed product, registered one cycle after fire.
REQ-024 Accumulator SHALL add the registered product one cycle later, wrapping modulo 2^64.
REQ-025 After the final pair's product is accumulated, SHALL enter EMIT; Y_valid SHALL rise 3 cycles after the final fire cycle.
REQ-026 EMIT: Y_data = accumulator, held stable with Y_valid until Y_ready; on transfer decrement rows-remaining; go LOAD_LEN if rows remain, else DONE.
REQ-027 DONE: Done=1 for exactly one cycle, then IDLE.
REQ-028 Calc_Begin outside IDLE SHALL be ignored; Ctrl_sig_* SHALL be stable while Busy.
REQ-029 Zero-length row SHALL emit Y_data=0 and consume no Xi or Val beats.
REQ-030 Excess Xi/Val beats beyond a row's length SHALL NOT be accepted until the next row is in ACCUM.

Reset
REQ-031 On rstn low: state IDLE; Busy, Done, Y_valid, Xi_ready, Val_ready, RowLen_ready = 0; Y_data, accumulator, counters, holding registers = 0.
REQ-032 Reset mid-operation SHALL discard held operands and partial sums; no Y or Done follows.

Structure
REQ-033 State encoding and precision codes (P16=0, P32=1, P64=2) SHALL live in shared package spmv_pkg.
REQ-034 Sign-extend plus registered multiply SHALL be sub-module spmv_sext_mul.

Verification
REQ-035 Row_Count=1, len=3, P64, Xi={1,2,3}, Val={4,5,6} -> single Y_data=32, then Done pulse.
REQ-036 P16 Xi=16'hFFFF, Val=16'h0002, len=1 -> Y_data=64'hFFFF_FFFF_FFFF_FFFE.
REQ-037 Row lengths {0,2}, Xi={7,7}, Val={1,1} -> Y_data=0 then 14; exactly 2 Xi beats consumed.
REQ-038 Y_ready low 10 cycles in EMIT -> Y_valid/Y_data stable, no new RowLen accepted until transfer.
REQ-039 Xi_valid asserted 5 cycles after Val_valid -> Val held, one fire only; result correct.
REQ-040 rstn asserted in ACCUM mid-row, then Row_Count=1 len=1 Xi=2 Val=3 -> Y_data=6, no stale data.
